// File: rtl/seq_pkg.sv
// Shared definitions for the sequence monitor: the tracked value table, FSM encoding and sizes.
package seq_pkg;

    localparam int unsigned SYNC_LEN = 2;
    localparam int unsigned ERRCNT_W = 8;
    localparam logic [1:0]  SC_LAST  = 2'(SYNC_LEN - 1);

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StSync    = 2'd1,
        StLocked  = 2'd2,
        StSuspect = 2'd3
    } state_e;

    // Value expected at each position of the 8-step cycle.
    function automatic logic [3:0] seq_at(input logic [2:0] i);
        logic [3:0] v;
        unique case (i)
            3'd0: v = 4'd4;
            3'd1: v = 4'd5;
            3'd2: v = 4'd14;
            3'd3: v = 4'd3;
            3'd4: v = 4'd6;
            3'd5: v = 4'd12;
            3'd6: v = 4'd11;
            default: v = 4'd13;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/seq_index.sv
// Combinational inverse of the sequence table: value -> {member, position}.
module seq_index
    import seq_pkg::*;
(
    input  logic [3:0] val,
    output logic       member,
    output logic [2:0] idx
);

    always_comb begin
        member = 1'b1;
        idx    = 3'd0;
        case (val)
            4'd4:    idx = 3'd0;
            4'd5:    idx = 3'd1;
            4'd14:   idx = 3'd2;
            4'd3:    idx = 3'd3;
            4'd6:    idx = 3'd4;
            4'd12:   idx = 3'd5;
            4'd11:   idx = 3'd6;
            4'd13:   idx = 3'd7;
            default: member = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_monitor.sv
// Tracks a cyclic 8-value counter sequence, locks after consecutive in-order samples and
// flags/counts ordering errors once locked.
module seq_monitor
    import seq_pkg::*;
(
    input  logic                C,
    input  logic                R,
    input  logic [3:0]          D,
    input  logic                V,
    output logic [2:0]          IDX,
    output logic [3:0]          NEXT,
    output logic                LOCK,
    output logic                ERR,
    output logic [ERRCNT_W-1:0] ERRCNT
);

    state_e              state_q, state_d;
    logic [1:0]          sc_q, sc_d;
    logic [2:0]          idx_q, idx_d;
    logic [3:0]          next_q, next_d;
    logic                lock_q, lock_d;
    logic                err_q, err_d;
    logic [ERRCNT_W-1:0] cnt_q, cnt_d;

    logic       d_member;
    logic [2:0] d_idx;
    logic [2:0] idx_inc;
    logic       correct;

    seq_index u_seq_index (
        .val    (D),
        .member (d_member),
        .idx    (d_idx)
    );

    assign idx_inc = idx_q + 3'd1;
    assign correct = (D == seq_at(idx_inc));

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (V) begin
            unique case (state_q)
                StHunt: begin
                    if (d_member) begin
                        state_d = StSync;
                        idx_d   = d_idx;
                        sc_d    = 2'd0;
                    end
                end
                StSync: begin
                    if (correct) begin
                        idx_d = idx_inc;
                        sc_d  = sc_q + 2'd1;
                        if (sc_q == SC_LAST) state_d = StLocked;
                    end else if (d_member) begin
                        idx_d = d_idx;
                        sc_d  = 2'd0;
                    end else begin
                        state_d = StHunt;
                        idx_d   = 3'd0;
                        sc_d    = 2'd0;
                    end
                end
                StLocked: begin
                    // Flywheel: advance even on a miss so a single glitch does not lose phase.
                    idx_d = idx_inc;
                    if (!correct) begin
                        err_d   = 1'b1;
                        state_d = StSuspect;
                    end
                end
                default: begin
                    if (correct) begin
                        idx_d   = idx_inc;
                        state_d = StLocked;
                    end else begin
                        err_d   = 1'b1;
                        idx_d   = 3'd0;
                        sc_d    = 2'd0;
                        state_d = StHunt;
                    end
                end
            endcase
        end
        if (err_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        next_d = (state_d == StHunt) ? 4'd0 : seq_at(idx_d + 3'd1);
        lock_d = (state_d == StLocked) || (state_d == StSuspect);
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= StHunt;
            sc_q    <= 2'd0;
            idx_q   <= 3'd0;
            next_q  <= 4'd0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            idx_q   <= idx_d;
            next_q  <= next_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IDX    = idx_q;
    assign NEXT   = next_q;
    assign LOCK   = lock_q;
    assign ERR    = err_q;
    assign ERRCNT = cnt_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor: lock, wrap, flywheel, loss of lock, gaps, saturation, reset.
module tb_seq_monitor;

    logic       C;
    logic       R;
    logic [3:0] D;
    logic       V;
    logic [2:0] IDX;
    logic [3:0] NEXT;
    logic       LOCK;
    logic       ERR;
    logic [7:0] ERRCNT;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] seq_tb [8];
    logic [2:0] e_idx;

    seq_monitor dut (
        .C      (C),
        .R      (R),
        .D      (D),
        .V      (V),
        .IDX    (IDX),
        .NEXT   (NEXT),
        .LOCK   (LOCK),
        .ERR    (ERR),
        .ERRCNT (ERRCNT)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step(input logic [3:0] d, input logic v);
        D = d;
        V = v;
        @(posedge C);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] idx, input logic [3:0] nxt,
                           input logic lck, input logic err, input logic [7:0] cnt);
        chk({tag, ".idx"},  8'(IDX),  8'(idx));
        chk({tag, ".next"}, 8'(NEXT), 8'(nxt));
        chk({tag, ".lock"}, 8'(LOCK), 8'(lck));
        chk({tag, ".err"},  8'(ERR),  8'(err));
        chk({tag, ".cnt"},  ERRCNT,   cnt);
    endtask

    initial begin
        seq_tb[0] = 4'd4;  seq_tb[1] = 4'd5;  seq_tb[2] = 4'd14; seq_tb[3] = 4'd3;
        seq_tb[4] = 4'd6;  seq_tb[5] = 4'd12; seq_tb[6] = 4'd11; seq_tb[7] = 4'd13;
        R = 1'b1;
        D = 4'd0;
        V = 1'b0;
        repeat (2) @(posedge C);
        #1;
        chk_all("reset", 3'd0, 4'd0, 1'b0, 1'b0, 8'd0);
        R = 1'b0;

        // Scenario 1: lock on 4,5,14
        step(4'd4, 1'b1);  chk_all("s1_a", 3'd0, 4'd5,  1'b0, 1'b0, 8'd0);
        step(4'd5, 1'b1);  chk_all("s1_b", 3'd1, 4'd14, 1'b0, 1'b0, 8'd0);
        step(4'd14, 1'b1); chk_all("s1_c", 3'd2, 4'd3,  1'b1, 1'b0, 8'd0);

        // Scenario 2: run around the cycle including the 13->4 wrap
        step(4'd3, 1'b1);  step(4'd6, 1'b1); step(4'd12, 1'b1);
        step(4'd11, 1'b1); chk_all("s2_6", 3'd6, 4'd13, 1'b1, 1'b0, 8'd0);
        step(4'd13, 1'b1); chk_all("s2_7", 3'd7, 4'd4,  1'b1, 1'b0, 8'd0);
        step(4'd4, 1'b1);  chk_all("s2_0", 3'd0, 4'd5,  1'b1, 1'b0, 8'd0);

        // Scenario 3: single miss is flywheeled, then recovered
        step(4'd5, 1'b1);  chk_all("s3_at1", 3'd1, 4'd14, 1'b1, 1'b0, 8'd0);
        step(4'd9, 1'b1);  chk_all("s3_miss", 3'd2, 4'd3, 1'b1, 1'b1, 8'd1);
        step(4'd3, 1'b1);  chk_all("s3_recov", 3'd3, 4'd6, 1'b1, 1'b0, 8'd1);

        // Reset mid-operation, relock, then two misses drop lock
        #2 R = 1'b1;
        #1 chk_all("mid_rst", 3'd0, 4'd0, 1'b0, 1'b0, 8'd0);
        R = 1'b0;
        step(4'd4, 1'b1); step(4'd5, 1'b1); step(4'd14, 1'b1);
        chk_all("s4_lock", 3'd2, 4'd3, 1'b1, 1'b0, 8'd0);
        step(4'd0, 1'b1);  chk_all("s4_miss1", 3'd3, 4'd6, 1'b1, 1'b1, 8'd1);
        step(4'd0, 1'b1);  chk_all("s4_miss2", 3'd0, 4'd0, 1'b0, 1'b1, 8'd2);
        step(4'd0, 1'b0);  chk_all("s4_idle",  3'd0, 4'd0, 1'b0, 1'b0, 8'd2);

        // Scenario 5: non-members ignored in HUNT, V=0 gaps ignored
        step(4'd7, 1'b1);  chk_all("s5_7",  3'd0, 4'd0, 1'b0, 1'b0, 8'd2);
        step(4'd0, 1'b0);
        step(4'd8, 1'b1);  chk_all("s5_8",  3'd0, 4'd0, 1'b0, 1'b0, 8'd2);
        step(4'd6, 1'b1);  chk_all("s5_6",  3'd4, 4'd12, 1'b0, 1'b0, 8'd2);
        step(4'd9, 1'b0);  chk_all("s5_gap", 3'd4, 4'd12, 1'b0, 1'b0, 8'd2);
        step(4'd12, 1'b1); chk_all("s5_12", 3'd5, 4'd11, 1'b0, 1'b0, 8'd2);
        step(4'd1, 1'b0);
        step(4'd11, 1'b1); chk_all("s5_11", 3'd6, 4'd13, 1'b1, 1'b0, 8'd2);

        // Scenario 6: miss/recover pairs until the counter saturates
        e_idx = 3'd6;
        for (int i = 0; i < 253; i++) begin
            step(4'd0, 1'b1);
            e_idx = e_idx + 3'd1;
            step(seq_tb[e_idx + 3'd1], 1'b1);
            e_idx = e_idx + 3'd1;
        end
        chk_all("s6_sat", e_idx, seq_tb[e_idx + 3'd1], 1'b1, 1'b0, 8'd255);
        step(4'd0, 1'b1);
        e_idx = e_idx + 3'd1;
        chk_all("s6_hold", e_idx, seq_tb[e_idx + 3'd1], 1'b1, 1'b1, 8'd255);
        // Reset between edges, while ERR is high
        #2 R = 1'b1;
        #1 chk_all("s6_rst", 3'd0, 4'd0, 1'b0, 1'b0, 8'd0);
        #1 R = 1'b0;
        step(4'd3, 1'b1);  chk_all("post_rst", 3'd3, 4'd6, 1'b0, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
